sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It is the successor to the fixed 8-bit x 16 FIFO, generalised in data width and depth. It adds programmable almost-full/almost-empty thresholds, a fill-level output, a read-data valid strobe, well-defined simultaneous read/write at the full and empty boundaries, and sticky error flags. It sits between producer and consumer blocks inside one clock domain.

---
 rtl/sync_fifo_param.sv | 140 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, a fill-level output, a read-valid strobe and sticky error flags.
//
// Optional feature macro: FIFO_FWFT_EN
//   undefined - registered read, data_out valid one cycle after an accepted rd (rd_valid = 1)
//   defined   - first-word-fall-through, data_out shows the head word while not empty
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   wr, data_in        write request and data
//   rd                 read request
//   data_out, rd_valid read data and its valid strobe
//   afull_th           almost-full threshold  (fifo_afull  = level >= afull_th)
//   aempty_th          almost-empty threshold (fifo_aempty = level <= aempty_th)
//   level              number of stored entries, 0..DEPTH
//   fifo_full/empty    level == DEPTH / level == 0
//   fifo_afull/aempty  threshold flags, combinational from level and thresholds
//   fifo_overflow      one-cycle pulse after a refused write
//   fifo_underflow     one-cycle pulse after a refused read
//   err_sticky         {overflow_seen, underflow_seen}, cleared by clr_err (set wins)
//   clr_err            synchronous clear of err_sticky
module sync_fifo_param #(
    parameter int unsigned  DATA_W = 8,
    parameter int unsigned  DEPTH  = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic [AW:0]       afull_th,
    input  logic [AW:0]       aempty_th,
    output logic [AW:0]       level,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_afull,
    output logic              fifo_aempty,
    output logic              fifo_overflow,
    output logic              fifo_underflow,
    output logic [1:0]        err_sticky,
    input  logic              clr_err
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and at least 4");
    end

    localparam logic [AW:0]   FullLvl = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LvlOne  = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [1:0]    err_q, err_d;
    logic          rd_ok, wr_ok;

    assign level          = level_q;
    assign fifo_full      = (level_q == FullLvl);
    assign fifo_empty     = (level_q == '0);
    assign fifo_afull     = (level_q >= afull_th);
    assign fifo_aempty    = (level_q <= aempty_th);
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = udf_q;
    assign err_sticky     = err_q;

    // A read on a full FIFO frees a slot, so the write on the same edge is taken.
    assign rd_ok = rd & ~fifo_empty;
    assign wr_ok = wr & (~fifo_full | rd_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_ok) wptr_d = wptr_q + PtrOne;
        if (rd_ok) rptr_d = rptr_q + PtrOne;
        if (wr_ok && !rd_ok) begin
            level_d = level_q + LvlOne;
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - LvlOne;
        end
        ovf_d = wr & ~wr_ok;
        udf_d = rd & ~rd_ok;
        // Clear first, then OR in new events so a same-edge set wins.
        err_d = clr_err ? 2'b00 : err_q;
        err_d = err_d | {ovf_d, udf_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_q] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = fifo_empty ? '0 : mem[rptr_q];
    assign rd_valid = ~fifo_empty;
`else
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) data_out_q <= mem[rptr_q];
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16). A queue-based reference
// model predicts every observable output; directed scenarios add explicit constant checks.
module tb_sync_fifo_param;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam int          ST_W   = (AW + 1) + 4 + 2 + 2 + 1 + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [AW:0]       afull_th = 5'd12;
    logic [AW:0]       aempty_th = 5'd3;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic [AW:0]       level;
    logic              fifo_full, fifo_empty, fifo_afull, fifo_aempty;
    logic              fifo_overflow, fifo_underflow;
    logic [1:0]        err_sticky;

    int vecs = 0;
    int errs = 0;

    sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr             (wr),
        .data_in        (data_in),
        .rd             (rd),
        .data_out       (data_out),
        .rd_valid       (rd_valid),
        .afull_th       (afull_th),
        .aempty_th      (aempty_th),
        .level          (level),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_afull     (fifo_afull),
        .fifo_aempty    (fifo_aempty),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow),
        .err_sticky     (err_sticky),
        .clr_err        (clr_err)
    );

    always #5 clk = ~clk;

    wire [ST_W-1:0] dut_st = {level, fifo_full, fifo_empty, fifo_afull, fifo_aempty,
                              fifo_overflow, fifo_underflow, err_sticky, rd_valid, data_out};

    // Reference model: contents as a queue plus the last-event outputs.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_rvalid = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;
    logic [1:0]        m_err = 2'b00;

    task automatic model_reset();
        q.delete();
        m_dout   = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_err    = 2'b00;
    endtask

    task automatic model_edge(input logic w, input logic [DATA_W-1:0] d, input logic r,
                              input logic c);
        int  n;
        bit  r_ok, w_ok;
        n    = q.size();
        r_ok = r && (n != 0);
        w_ok = w && ((n != DEPTH) || r_ok);
        m_rvalid = r_ok;
        if (r_ok) m_dout = q.pop_front();
        if (w_ok) q.push_back(d);
        m_ovf = w && !w_ok;
        m_udf = r && !r_ok;
        if (c) m_err = 2'b00;
        m_err = m_err | {m_ovf, m_udf};
    endtask

    function automatic logic [ST_W-1:0] model_st();
        int                n;
        logic [DATA_W-1:0] dout;
        logic              rv;
        n = q.size();
`ifdef FIFO_FWFT_EN
        dout = (n != 0) ? q[0] : '0;
        rv   = (n != 0);
`else
        dout = m_dout;
        rv   = m_rvalid;
`endif
        return {(AW + 1)'(n), n == DEPTH, n == 0, n >= int'(afull_th), n <= int'(aempty_th),
                m_ovf, m_udf, m_err, rv, dout};
    endfunction

    // One clock: inputs held across the rising edge, outputs settled at edge + 1.
    task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r,
                         input logic c);
        wr      = w;
        data_in = d;
        rd      = r;
        clr_err = c;
        @(posedge clk);
        model_edge(w, d, r, c);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic apply_reset();
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [ST_W-1:0] exp;
        afull_th  = 5'd12;
        aempty_th = 5'd3;
        apply_reset();
        exp = model_st();
        vecs++;
        if (dut_st !== exp) begin
            errs++;
            $display("FAIL reset status: got %h want %h", dut_st, exp);
        end
        vecs++;
        if (level !== 5'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || err_sticky !== 2'b00)
        begin
            errs++;
            $display("FAIL reset flags: got lvl=%0d e=%b f=%b err=%b want 0 1 0 00",
                     level, fifo_empty, fifo_full, err_sticky);
        end
        afull_th = 5'd0;
        #1;
        vecs++;
        if (fifo_afull !== 1'b1) begin
            errs++;
            $display("FAIL reset afull_th=0: got %b want 1", fifo_afull);
        end
        aempty_th = 5'd0;
        #1;
        vecs++;
        if (fifo_aempty !== 1'b1) begin
            errs++;
            $display("FAIL reset aempty_th=0: got %b want 1", fifo_aempty);
        end
        afull_th  = 5'd12;
        aempty_th = 5'd3;
    endtask

    task automatic test_fill_overflow();
        logic [ST_W-1:0] exp;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
            exp = model_st();
            vecs++;
            if (dut_st !== exp) begin
                errs++;
                $display("FAIL fill[%0d] status: got %h want %h", i, dut_st, exp);
            end
            if (i == 15) begin
                vecs++;
                if (fifo_full !== 1'b1 || level !== 5'd16) begin
                    errs++;
                    $display("FAIL fill full: got f=%b lvl=%0d want 1 16", fifo_full, level);
                end
            end
        end
        vecs++;
        if (fifo_overflow !== 1'b1 || err_sticky !== 2'b10) begin
            errs++;
            $display("FAIL overflow pulse: got ovf=%b err=%b want 1 10",
                     fifo_overflow, err_sticky);
        end
        // Thresholds above DEPTH: afull never, aempty always.
        afull_th  = 5'd20;
        aempty_th = 5'd31;
        cycle(1'b0, '0, 1'b0, 1'b0);
        vecs++;
        if (fifo_overflow !== 1'b0 || fifo_afull !== 1'b0 || fifo_aempty !== 1'b1) begin
            errs++;
            $display("FAIL overflow end/th>DEPTH: got ovf=%b af=%b ae=%b want 0 0 1",
                     fifo_overflow, fifo_afull, fifo_aempty);
        end
        afull_th  = 5'd12;
        aempty_th = 5'd3;
    endtask

    task automatic test_drain_underflow();
        logic [ST_W-1:0] exp;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            exp = model_st();
            vecs++;
            if (dut_st !== exp) begin
                errs++;
                $display("FAIL drain[%0d] status: got %h want %h", i, dut_st, exp);
            end
`ifdef FIFO_FWFT_EN
            if (i < 15) begin
                vecs++;
                if (data_out !== DATA_W'(i + 1) || rd_valid !== 1'b1) begin
                    errs++;
                    $display("FAIL drain[%0d] head: got %h/%b want %h/1",
                             i, data_out, rd_valid, i + 1);
                end
            end
`else
            if (i < 16) begin
                vecs++;
                if (data_out !== DATA_W'(i) || rd_valid !== 1'b1) begin
                    errs++;
                    $display("FAIL drain[%0d] data: got %h/%b want %h/1",
                             i, data_out, rd_valid, i);
                end
            end
`endif
        end
        vecs++;
        if (fifo_underflow !== 1'b1 || fifo_empty !== 1'b1 || err_sticky !== 2'b11) begin
            errs++;
            $display("FAIL underflow: got udf=%b e=%b err=%b want 1 1 11",
                     fifo_underflow, fifo_empty, err_sticky);
        end
        // Clear with a same-edge underflow: set wins for that bit only.
        cycle(1'b0, '0, 1'b1, 1'b1);
        vecs++;
        if (err_sticky !== 2'b01) begin
            errs++;
            $display("FAIL clr vs set: got %b want 01", err_sticky);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        vecs++;
        if (err_sticky !== 2'b00 || fifo_underflow !== 1'b0) begin
            errs++;
            $display("FAIL clr_err: got err=%b udf=%b want 00 0", err_sticky, fifo_underflow);
        end
    endtask

    task automatic test_full_rdwr();
        logic [ST_W-1:0] exp;
        for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(8'h10 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        exp = model_st();
        vecs++;
        if (dut_st !== exp || level !== 5'd16 || fifo_overflow !== 1'b0) begin
            errs++;
            $display("FAIL full rd&wr: got %h want %h (lvl 16, no ovf)", dut_st, exp);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            exp = model_st();
            vecs++;
            if (dut_st !== exp) begin
                errs++;
                $display("FAIL full drain[%0d]: got %h want %h", i, dut_st, exp);
            end
`ifdef FIFO_FWFT_EN
            if (i == 14) begin
`else
            if (i == 15) begin
`endif
                vecs++;
                if (data_out !== 8'hAA) begin
                    errs++;
                    $display("FAIL full rd&wr data: got %h want aa", data_out);
                end
            end
        end
    endtask

    task automatic test_empty_rdwr();
        logic [ST_W-1:0] exp;
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        exp = model_st();
        vecs++;
        if (dut_st !== exp || fifo_underflow !== 1'b1 || level !== 5'd1) begin
            errs++;
            $display("FAIL empty rd&wr: got %h want %h (udf 1, lvl 1)", dut_st, exp);
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        exp = model_st();
        vecs++;
`ifdef FIFO_FWFT_EN
        if (dut_st !== exp || fifo_empty !== 1'b1) begin
`else
        if (dut_st !== exp || data_out !== 8'h55 || rd_valid !== 1'b1) begin
`endif
            errs++;
            $display("FAIL empty rd&wr readback: got %h want %h", dut_st, exp);
        end
    endtask

    task automatic test_wrap_thresholds();
        logic [ST_W-1:0]   exp;
        logic [DATA_W-1:0] nxt;
        int                written, n;
        bit                w, r;
        afull_th  = 5'd12;
        aempty_th = 5'd3;
        apply_reset();
        nxt     = 8'h80;
        written = 0;
        for (int c = 0; c < 400 && (written < 40 || q.size() != 0); c++) begin
            if (written < 40) begin
                w = ($urandom_range(0, 99) < ((written < 20) ? 85 : 50));
                r = ($urandom_range(0, 99) < ((written < 20) ? 25 : 65));
            end else begin
                w = 1'b0;
                r = 1'b1;
            end
            n = q.size();
            cycle(w, nxt, r, 1'b0);
            if (w && (n != DEPTH || (r && n != 0))) begin
                written++;
                nxt++;
            end
            exp = model_st();
            vecs++;
            if (dut_st !== exp) begin
                errs++;
                $display("FAIL wrap[%0d] status: got %h want %h", c, dut_st, exp);
            end
        end
        vecs++;
        if (written < 40 || fifo_empty !== 1'b1) begin
            errs++;
            $display("FAIL wrap budget: got %0d writes empty=%b want 40 1", written, fifo_empty);
        end
    endtask

    task automatic test_random();
        logic [ST_W-1:0] exp;
        for (int c = 0; c < 300; c++) begin
            if (c % 20 == 0) begin
                afull_th  = 5'($urandom_range(0, DEPTH + 3));
                aempty_th = 5'($urandom_range(0, DEPTH + 3));
            end
            cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0);
            exp = model_st();
            vecs++;
            if (dut_st !== exp) begin
                errs++;
                $display("FAIL random[%0d] status: got %h want %h", c, dut_st, exp);
            end
        end
        afull_th  = 5'd12;
        aempty_th = 5'd3;
    endtask

    task automatic test_reset_midstream();
        logic [ST_W-1:0] exp;
        apply_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b0);
        vecs++;
        if (level !== 5'd7) begin
            errs++;
            $display("FAIL midreset prefill: got lvl=%0d want 7", level);
        end
        wr      = 1'b1;
        data_in = 8'h99;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        exp = model_st();
        vecs++;
        if (dut_st !== exp || level !== 5'd0 || fifo_empty !== 1'b1) begin
            errs++;
            $display("FAIL midreset immediate: got %h want %h", dut_st, exp);
        end
        wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        exp = model_st();
        vecs++;
`ifdef FIFO_FWFT_EN
        if (dut_st !== exp || data_out !== 8'h3C || fifo_empty !== 1'b0) begin
`else
        if (dut_st !== exp || fifo_empty !== 1'b0) begin
`endif
            errs++;
            $display("FAIL midreset write: got %h want %h", dut_st, exp);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        exp = model_st();
        vecs++;
`ifdef FIFO_FWFT_EN
        if (dut_st !== exp || fifo_empty !== 1'b1) begin
`else
        if (dut_st !== exp || data_out !== 8'h3C || rd_valid !== 1'b1) begin
`endif
            errs++;
            $display("FAIL midreset read: got %h want %h", dut_st, exp);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_rdwr();
        test_empty_rdwr();
        test_wrap_thresholds();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
